// File: rtl/lsb_mem_port_pkg.sv
// Shared definitions for lsb_mem_port: FSM states, access size codes and
// helpers for byte counts and alignment.
package lsb_mem_port_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Size code 3 is illegal and behaves as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    return 3'd1;
         SZ_H:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_B:    return 1'b0;
         SZ_H:    return addr_lo[0];
         default: return addr_lo != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/lsb_mem_port_load_assembler.sv
// Collects returned load bytes into little-endian slots and produces the
// extended load word, including a byte arriving in the current cycle.
module lsb_load_assembler
   import lsb_mem_port_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        capture,
   input  logic [7:0]  byte_in,
   input  logic [2:0]  n_bytes,
   input  logic        sign_ext,
   output logic [31:0] word_next
);

   logic [7:0] slot [4];
   logic [7:0] merged [4];
   logic [1:0] r;
   logic [1:0] top_idx;
   logic [7:0] top_byte;
   logic [7:0] fill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= 2'd0;
         for (int i = 0; i < 4; i++) slot[i] <= 8'h00;
      end else if (clear) begin
         r <= 2'd0;
         for (int i = 0; i < 4; i++) slot[i] <= 8'h00;
      end else if (capture) begin
         slot[r] <= byte_in;
         r       <= r + 2'd1;
      end
   end

   assign top_idx = 2'(n_bytes - 3'd1);

   // Merge the in-flight byte so the caller can register the final word on
   // the same edge that captures the last return.
   always_comb begin
      for (int i = 0; i < 4; i++) merged[i] = slot[i];
      if (capture) merged[r] = byte_in;
      top_byte  = merged[top_idx];
      fill      = (sign_ext && top_byte[7]) ? 8'hFF : 8'h00;
      word_next = '0;
      for (int i = 0; i < 4; i++) begin
         word_next[8*i +: 8] = (3'(i) < n_bytes) ? merged[i] : fill;
      end
   end

endmodule

// File: rtl/lsb_mem_port.sv
// Byte-serial load/store initiator for the LSB port of mem_controller.
// Optional misalignment trap: define LSB_MEM_PORT_MISALIGN_CHECK_EN.
module lsb_mem_port
   import lsb_mem_port_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              flush_in,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              lsb_en,
   output logic              lsb_wr,
   output logic [ADDR_W-1:0] lsb_addr,
   output logic [7:0]        lsb_data,
   input  logic [7:0]        lsb_read_data,
   input  logic              lsb_valid,
   output logic [1:0]        dbg_state
);

   state_e      state;
   logic        wr_q;
   logic        sgn_q;
   logic [31:0] wdata_q;
   logic [2:0]  n_q;
   logic [1:0]  k;
   logic [1:0]  k_next;
   logic        accept;
   logic        flush_load;
   logic        capture;
   logic [31:0] load_word;

   assign dbg_state  = state;
   assign k_next     = k + 2'd1;
   // A flush on the accept cycle wins, so the request simply waits.
   assign accept     = (state == IDLE) && req_valid && !flush_in;
   assign flush_load = flush_in && !wr_q && ((state == ISSUE) || (state == DRAIN));
   assign capture    = lsb_valid && !wr_q && ((state == ISSUE) || (state == DRAIN));

`ifdef LSB_MEM_PORT_MISALIGN_CHECK_EN
   logic err_q;
   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         lsb_en     <= 1'b0;
         lsb_wr     <= 1'b0;
         lsb_addr   <= '0;
         lsb_data   <= '0;
         wr_q       <= 1'b0;
         sgn_q      <= 1'b0;
         wdata_q    <= '0;
         n_q        <= 3'd1;
         k          <= 2'd0;
`ifdef LSB_MEM_PORT_MISALIGN_CHECK_EN
         err_q      <= 1'b0;
`endif
      end else begin
         resp_valid <= 1'b0;
`ifdef LSB_MEM_PORT_MISALIGN_CHECK_EN
         err_q      <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  wr_q      <= req_wr;
                  sgn_q     <= req_signed;
                  wdata_q   <= req_wdata;
                  n_q       <= size_bytes(req_size);
                  k         <= 2'd0;
`ifdef LSB_MEM_PORT_MISALIGN_CHECK_EN
                  if (misaligned(req_size, req_addr[1:0])) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     err_q      <= 1'b1;
                  end else begin
`else
                  begin
`endif
                     state    <= ISSUE;
                     lsb_en   <= 1'b1;
                     lsb_wr   <= req_wr;
                     lsb_addr <= req_addr;
                     lsb_data <= req_wdata[7:0];
                  end
               end
            end
            ISSUE: begin
               if (flush_load) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  lsb_en    <= 1'b0;
                  lsb_wr    <= 1'b0;
               end else if ({1'b0, k} == n_q - 3'd1) begin
                  lsb_en <= 1'b0;
                  lsb_wr <= 1'b0;
                  if (wr_q) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  k        <= k_next;
                  lsb_addr <= lsb_addr + ADDR_W'(1);
                  lsb_data <= wdata_q[{k_next, 3'b000} +: 8];
               end
            end
            DRAIN: begin
               if (flush_load) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_word;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

   lsb_load_assembler u_asm (
      .clk       (clk_in),
      .rst_n     (rst_n_in),
      .clear     (accept || flush_load),
      .capture   (capture),
      .byte_in   (lsb_read_data),
      .n_bytes   (n_q),
      .sign_ext  (sgn_q),
      .word_next (load_word)
   );

endmodule
